// File: rtl/fta_bus_pkg.sv
// rtl/fta_bus_pkg.sv - fta bus command request type shared with the mpmc11 channel FIFOs
package fta_bus_pkg;

    typedef struct packed {
        logic [7:0]   cmd;
        logic [7:0]   cid;
        logic [31:0]  sel;
        logic [31:0]  adr;
        logic [175:0] dat;
    } fta_cmd_request256_t;

endpackage

// File: rtl/mpmc11_pkg.sv
// rtl/mpmc11_pkg.sv - mpmc11 channel arbiter state encoding and defaults
package mpmc11_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        VALID = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int MPMC11_AGE_LIMIT = 48;

endpackage

// File: rtl/mpmc11_rr_pick.sv
// rtl/mpmc11_rr_pick.sv - rotate-priority encoder: first set bit after rr_ptr, wrapping
module mpmc11_rr_pick #(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0]         eligible,
    input  logic [$clog2(NCH)-1:0] rr_ptr,
    output logic [$clog2(NCH)-1:0] idx,
    output logic                   found
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NCH);
            if (!found && eligible[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpmc11_chan_arbiter.sv
// rtl/mpmc11_chan_arbiter.sv - round-robin channel arbiter with age override, paced by select_next
module mpmc11_chan_arbiter
    import mpmc11_pkg::*;
    import fta_bus_pkg::*;
#(
    parameter int NCH       = 8,
    parameter int AGE_W     = 6,
    parameter int AGE_LIMIT = MPMC11_AGE_LIMIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             req,
    input  logic [NCH-1:0]             chan_en,
    input  logic                       select_next,
    input  fta_cmd_request256_t        fifo_dout [NCH],
    output logic [NCH-1:0]             rd_en,
    output logic [$clog2(NCH)-1:0]     gnt_ch,
    output fta_cmd_request256_t        fifo_out,
    output logic                       fifo_v
);

    localparam int IW = $clog2(NCH);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    arb_state_t       state, state_nxt;
    logic [NCH-1:0]   eligible, starving;
    logic [AGE_W-1:0] age [NCH];
    logic [IW-1:0]    rr_ptr, rr_idx, starve_idx, win;
    logic             rr_found, starve_found, grant;

    assign eligible = req & chan_en;

    always_comb begin
        starving = '0;
        for (int i = 0; i < NCH; i++) begin
            starving[i] = eligible[i] && (age[i] >= AGE_W'(AGE_LIMIT));
        end
    end

    mpmc11_rr_pick #(.NCH(NCH)) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .idx      (rr_idx),
        .found    (rr_found)
    );

    // Searching from NCH-1 makes the rotate encoder a plain lowest-index pick.
    mpmc11_rr_pick #(.NCH(NCH)) u_starve_pick (
        .eligible (starving),
        .rr_ptr   (IW'(NCH - 1)),
        .idx      (starve_idx),
        .found    (starve_found)
    );

    assign win = starve_found ? starve_idx : rr_idx;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            ARB: begin
                if (select_next && rr_found) begin
                    grant     = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID:   if (!select_next) state_nxt = WAIT;
            WAIT:    if (select_next)  state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            rr_ptr   <= IW'(NCH - 1);
            rd_en    <= '0;
            gnt_ch   <= '0;
            fifo_out <= '0;
            fifo_v   <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_en <= '0;
            if (grant) begin
                gnt_ch   <= win;
                fifo_out <= fifo_dout[win];
                rd_en    <= NCH'(1) << win;
                rr_ptr   <= win;
                fifo_v   <= 1'b1;
            end else if (state == VALID && !select_next) begin
                fifo_v <= 1'b0;
            end
        end
    end

    // Ages move only on grant edges; losing an eligibility bit always clears.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst || !eligible[i]) begin
                age[i] <= '0;
            end else if (grant) begin
                if (IW'(i) == win) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mpmc11_chan_arbiter.sv
// tb/tb_mpmc11_chan_arbiter.sv - self-checking bench for mpmc11_chan_arbiter
module tb_mpmc11_chan_arbiter;
    import fta_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, rst4;
    logic [7:0]          req8, en8, rd8;
    logic [3:0]          req4, en4, rd4;
    logic                sel8, sel4, v8, v4;
    logic [2:0]          gnt8;
    logic [1:0]          gnt4;
    fta_cmd_request256_t dout8 [8];
    fta_cmd_request256_t dout4 [4];
    fta_cmd_request256_t out8, out4;

    mpmc11_chan_arbiter #(.NCH(8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .chan_en(en8), .select_next(sel8),
        .fifo_dout(dout8), .rd_en(rd8), .gnt_ch(gnt8), .fifo_out(out8), .fifo_v(v8)
    );

    // Small instance with a low age limit so starvation overrides round-robin order.
    mpmc11_chan_arbiter #(.NCH(4), .AGE_W(2), .AGE_LIMIT(2)) dut4 (
        .clk(clk), .rst(rst4), .req(req4), .chan_en(en4), .select_next(sel4),
        .fifo_dout(dout4), .rd_en(rd4), .gnt_ch(gnt4), .fifo_out(out4), .fifo_v(v4)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] en;
        logic       sel;
        logic [7:0] rd;
        int         gnt;
        logic       v;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input bit ok, input string name, input string got, input string want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, got, want);
        end
    endtask

    function automatic fta_cmd_request256_t pat(input int ch, input int tag);
        logic [255:0] b;
        b = {8{32'hC0DE0000 + 32'(ch * 256 + tag)}};
        return fta_cmd_request256_t'(b);
    endfunction

    function automatic fta_cmd_request256_t rand_cmd();
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom;
        return fta_cmd_request256_t'(b);
    endfunction

    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] e, input logic s,
                                input logic [7:0] rd, input int g, input logic v);
        vec_t t;
        t.req = r; t.en = e; t.sel = s; t.rd = rd; t.gnt = g; t.v = v;
        return t;
    endfunction

    task automatic wait_grant8(output int g, output logic [7:0] r);
        g = -1;
        r = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rd8 != 0) begin
                g = int'(gnt8);
                r = rd8;
                break;
            end
        end
    endtask

    task automatic wait_grant4(output int g, output logic [3:0] r);
        g = -1;
        r = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rd4 != 0) begin
                g = int'(gnt4);
                r = rd4;
                break;
            end
        end
    endtask

    // Reference model for the 4-channel instance, kept as plain integers.
    localparam int M_N = 4, M_LIMIT = 2, M_AGE_MAX = 3;
    int                  m_last, m_gnt;
    int                  m_age [M_N];
    bit                  m_busy, m_cool;
    logic [3:0]          m_rd;
    logic                m_v;
    fta_cmd_request256_t m_out;

    task automatic model_reset();
        m_last = M_N - 1;
        for (int i = 0; i < M_N; i++) m_age[i] = 0;
        m_busy = 0; m_cool = 0;
        m_rd = '0; m_gnt = 0; m_v = 1'b0; m_out = '0;
    endtask

    task automatic model_step(input logic r_rst, input logic [3:0] r, input logic [3:0] e,
                              input logic s);
        logic [3:0] elig;
        int         w;
        if (r_rst) begin
            model_reset();
            return;
        end
        elig = r & e;
        w    = -1;
        m_rd = '0;
        if (!m_busy && !m_cool) begin
            if (s && elig != 0) begin
                for (int i = 0; i < M_N; i++)
                    if (w < 0 && elig[i] && m_age[i] >= M_LIMIT) w = i;
                for (int k = 1; k <= M_N; k++)
                    if (w < 0 && elig[(m_last + k) % M_N]) w = (m_last + k) % M_N;
                m_rd   = 4'(1) << w;
                m_gnt  = w;
                m_out  = dout4[w];
                m_v    = 1'b1;
                m_last = w;
                m_busy = 1;
                for (int i = 0; i < M_N; i++)
                    if (elig[i]) m_age[i] = (i == w) ? 0 :
                                            ((m_age[i] + 1 > M_AGE_MAX) ? M_AGE_MAX : m_age[i] + 1);
            end
        end else if (m_busy) begin
            if (!s) begin
                m_v    = 1'b0;
                m_busy = 0;
                m_cool = 1;
            end
        end else if (s) begin
            m_cool = 0;
        end
        for (int i = 0; i < M_N; i++)
            if (!elig[i]) m_age[i] = 0;
    endtask

    initial begin
        int         g;
        logic [7:0] r8;
        logic [3:0] r4v;
        int         exp4 [8];
        logic [3:0] req4_seq [8];

        rst = 1'b1; rst4 = 1'b1;
        req8 = '0; en8 = 8'hFF; sel8 = 1'b0;
        req4 = '0; en4 = 4'hF;  sel4 = 1'b0;
        for (int i = 0; i < 8; i++) dout8[i] = pat(i, 0);
        for (int i = 0; i < 4; i++) dout4[i] = pat(i, 1);
        tick();
        tick();

        chk(rd8 == 0 && gnt8 == 0 && v8 == 0 && out8 == '0, "reset8",
            $sformatf("rd=%h gnt=%0d v=%b", rd8, gnt8, v8), "rd=00 gnt=0 v=0 out=0");
        chk(rd4 == 0 && gnt4 == 0 && v4 == 0 && out4 == '0, "reset4",
            $sformatf("rd=%h gnt=%0d v=%b", rd4, gnt4, v4), "rd=0 gnt=0 v=0 out=0");
        rst = 1'b0;

        // Single requester, mask, hold/return handshake, idle select in ARB.
        tbl.push_back(mk(8'h04, 8'hFF, 1, 8'h04, 2, 1));
        tbl.push_back(mk(8'h04, 8'hFF, 1, 8'h00, 2, 1));
        tbl.push_back(mk(8'h04, 8'hFF, 1, 8'h00, 2, 1));
        tbl.push_back(mk(8'h04, 8'hFF, 0, 8'h00, 2, 0));
        tbl.push_back(mk(8'h04, 8'hFF, 0, 8'h00, 2, 0));
        tbl.push_back(mk(8'h04, 8'hFF, 1, 8'h00, 2, 0));
        tbl.push_back(mk(8'h03, 8'h02, 1, 8'h02, 1, 1));
        tbl.push_back(mk(8'h03, 8'h02, 0, 8'h00, 1, 0));
        tbl.push_back(mk(8'h03, 8'h02, 1, 8'h00, 1, 0));
        tbl.push_back(mk(8'h03, 8'h02, 1, 8'h02, 1, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(8'h00, 8'h02, 1, 8'h00, 1, 1));
        tbl.push_back(mk(8'h00, 8'h02, 0, 8'h00, 1, 0));
        tbl.push_back(mk(8'hFF, 8'hFF, 1, 8'h00, 1, 0));
        tbl.push_back(mk(8'hFF, 8'hFF, 1, 8'h04, 2, 1));
        tbl.push_back(mk(8'hFF, 8'hFF, 0, 8'h00, 2, 0));
        tbl.push_back(mk(8'hFF, 8'hFF, 1, 8'h00, 2, 0));
        tbl.push_back(mk(8'hFF, 8'hFF, 0, 8'h00, 2, 0));
        tbl.push_back(mk(8'hFF, 8'hFF, 1, 8'h08, 3, 1));

        foreach (tbl[n]) begin
            req8 = tbl[n].req; en8 = tbl[n].en; sel8 = tbl[n].sel;
            tick();
            chk(rd8 == tbl[n].rd && int'(gnt8) == tbl[n].gnt && v8 == tbl[n].v &&
                out8 == pat(tbl[n].gnt, 0),
                $sformatf("vec%0d", n),
                $sformatf("rd=%h gnt=%0d v=%b", rd8, gnt8, v8),
                $sformatf("rd=%h gnt=%0d v=%b", tbl[n].rd, tbl[n].gnt, tbl[n].v));
        end

        // Round-robin order from reset with all channels requesting.
        sel8 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; req8 = 8'hFF; en8 = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            sel8 = 1'b1;
            wait_grant8(g, r8);
            chk(g == k % 8 && r8 == (8'(1) << (k % 8)) && out8 == pat(k % 8, 0),
                $sformatf("rr%0d", k), $sformatf("gnt=%0d rd=%h", g, r8),
                $sformatf("gnt=%0d", k % 8));
            tick();
            sel8 = 1'b0;
            tick();
        end

        // Reset while the grant is being presented.
        sel8 = 1'b1;
        wait_grant8(g, r8);
        tick();
        chk(v8 == 1'b1, "pre_rst_valid", $sformatf("v=%b", v8), "v=1");
        rst = 1'b1;
        tick();
        chk(rd8 == 0 && v8 == 0 && gnt8 == 0 && out8 == '0, "rst_mid_valid",
            $sformatf("rd=%h gnt=%0d v=%b", rd8, gnt8, v8), "rd=00 gnt=0 v=0 out=0");
        rst = 1'b0;
        tick();
        chk(rd8 == 8'h01 && gnt8 == 0 && v8 == 1, "post_rst_grant",
            $sformatf("rd=%h gnt=%0d v=%b", rd8, gnt8, v8), "rd=01 gnt=0 v=1");
        sel8 = 1'b0; req8 = '0;

        // Starvation override on the 4-channel instance (limit 2, ages saturate at 3).
        exp4     = '{0, 1, 2, 0, 1, 2, 3, 0};
        req4_seq = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h8, 4'hF};
        rst4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req4 = req4_seq[k];
            sel4 = 1'b1;
            wait_grant4(g, r4v);
            chk(g == exp4[k] && r4v == (4'(1) << exp4[k]) && out4 == pat(exp4[k], 1),
                $sformatf("starve%0d", k), $sformatf("gnt=%0d rd=%h", g, r4v),
                $sformatf("gnt=%0d", exp4[k]));
            sel4 = 1'b0;
            tick();
        end

        // Randomized run against the reference model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rst4 = (c == 0) || ($urandom_range(0, 63) == 0);
            req4 = 4'($urandom);
            en4  = 4'($urandom | $urandom);
            sel4 = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < 4; i++) dout4[i] = rand_cmd();
            model_step(rst4, req4, en4, sel4);
            tick();
            chk(rd4 == m_rd && int'(gnt4) == m_gnt && v4 == m_v && out4 == m_out,
                $sformatf("rand%0d", c),
                $sformatf("rd=%h gnt=%0d v=%b out=%h", rd4, gnt4, v4, out4),
                $sformatf("rd=%h gnt=%0d v=%b out=%h", m_rd, m_gnt, m_v, m_out));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
